// File: rtl/bird_column_ctrl_if.sv
// ---------------------------------------------------------------------------
// bird_column_ctrl_if
// Bundle of the bird controller's game-side signals.
//   flap      : flap key, already synchronised (driven by the master)
//   pipe_col  : wall occupancy of the bird column, bit r = wall at row r
//   bird_row  : one-hot bird LED for the column (blanked while blinking dead)
//   bird_pos  : bird row index, 0 = ground
//   tick      : one-cycle game-tick pulse for pipe scrolling
//   playing   : game in PLAY
//   dead      : game in DEAD
// Modports: master = game/pipe logic side, slave = bird controller side.
// ---------------------------------------------------------------------------
interface bird_column_ctrl_if #(
  parameter int ROWS = 8
) ();
  localparam int PW = $clog2(ROWS);

  logic            flap;
  logic [ROWS-1:0] pipe_col;
  logic [ROWS-1:0] bird_row;
  logic [PW-1:0]   bird_pos;
  logic            tick;
  logic            playing;
  logic            dead;

  modport master (
    output flap, pipe_col,
    input  bird_row, bird_pos, tick, playing, dead
  );

  modport slave (
    input  flap, pipe_col,
    output bird_row, bird_pos, tick, playing, dead
  );
endinterface

// File: rtl/bird_column_ctrl.sv
// ---------------------------------------------------------------------------
// bird_column_ctrl
// Bird controller for the LED-matrix Flappy Bird game. Keeps the bird row,
// applies gravity once per game tick, raises the bird on flap presses,
// detects ground and pipe collisions and sequences IDLE/PLAY/DEAD.
// Ports:
//   clock : system clock
//   reset : synchronous, active-high
//   bus   : bird_column_ctrl_if.slave (flap, pipe_col in; bird_row,
//           bird_pos, tick, playing, dead out)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for first flap, bird parked at START_ROW, tick stopped
// PLAY  | gravity/flap per tick, pipe collision checked every cycle
// DEAD  | bird frozen and blinking on ticks, flap returns to IDLE
// ---------------------------------------------------------------------------
module bird_column_ctrl #(
  parameter int ROWS        = 8,
  parameter int TICK_DIV    = 1792,
  parameter int START_ROW   = 3,
  parameter int FLAP_HEIGHT = 1
) (
  input  logic clock,
  input  logic reset,
  bird_column_ctrl_if.slave bus
);
  localparam int PW = $clog2(ROWS);
  localparam int CW = $clog2(TICK_DIV);

  localparam logic [PW-1:0] START_POS = PW'(START_ROW);
  localparam logic [PW-1:0] TOP_POS   = PW'(ROWS - 1);
  localparam logic [PW:0]   TOP_EXT   = (PW + 1)'(ROWS - 1);
  localparam logic [PW:0]   FLAP_EXT  = (PW + 1)'(FLAP_HEIGHT);
  localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DEAD = 2'd2
  } state_t;

  state_t        r_state, w_state_nx;
  logic [PW-1:0] r_pos, w_pos_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic          r_flap_q;
  logic          r_pending, w_pending_nx;
  logic          r_blink, w_blink_nx;

  logic          w_flap_edge;
  logic          w_tick;
  logic [CW-1:0] w_cnt_adv;
  logic [PW:0]   w_pos_up_ext;
  logic [PW-1:0] w_pos_up;

  assign w_flap_edge = bus.flap & ~r_flap_q;
  // Divider is held at 0 in IDLE, so a tick can only fire in PLAY/DEAD.
  assign w_tick      = (r_state != IDLE) && (r_cnt == CNT_LAST);
  assign w_cnt_adv   = w_tick ? '0 : r_cnt + CW'(1);

  // Extra bit keeps the sum from wrapping before the top-row clamp.
  assign w_pos_up_ext = {1'b0, r_pos} + FLAP_EXT;
  assign w_pos_up     = (w_pos_up_ext > TOP_EXT) ? TOP_POS : w_pos_up_ext[PW-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pos     <= START_POS;
      r_cnt     <= '0;
      r_flap_q  <= 1'b0;
      r_pending <= 1'b0;
      r_blink   <= 1'b1;
    end else begin
      r_state   <= w_state_nx;
      r_pos     <= w_pos_nx;
      r_cnt     <= w_cnt_nx;
      r_flap_q  <= bus.flap;
      r_pending <= w_pending_nx;
      r_blink   <= w_blink_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_pos_nx     = r_pos;
    w_cnt_nx     = r_cnt;
    w_pending_nx = r_pending;
    w_blink_nx   = r_blink;

    unique case (r_state)
      IDLE: begin
        w_pos_nx     = START_POS;
        w_cnt_nx     = '0;
        w_pending_nx = 1'b0;
        w_blink_nx   = 1'b1;
        if (w_flap_edge) w_state_nx = PLAY;
      end

      PLAY: begin
        w_cnt_nx = w_cnt_adv;
        // Wall hit wins over any move scheduled for this same tick.
        if (bus.pipe_col[r_pos]) begin
          w_state_nx   = DEAD;
          w_pending_nx = 1'b0;
        end else if (w_tick) begin
          w_pending_nx = 1'b0;
          if (r_pending || w_flap_edge) begin
            w_pos_nx = w_pos_up;
          end else if (r_pos == '0) begin
            w_state_nx = DEAD;
          end else begin
            w_pos_nx = r_pos - PW'(1);
          end
        end else if (w_flap_edge) begin
          w_pending_nx = 1'b1;
        end
      end

      DEAD: begin
        // The edge that killed the bird was consumed in PLAY; r_flap_q
        // is already high here, so it cannot also restart the game.
        if (w_flap_edge) begin
          w_state_nx = IDLE;
          w_pos_nx   = START_POS;
          w_cnt_nx   = '0;
          w_blink_nx = 1'b1;
        end else begin
          w_cnt_nx = w_cnt_adv;
          if (w_tick) w_blink_nx = ~r_blink;
        end
      end

      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  assign bus.bird_pos = r_pos;
  assign bus.bird_row = ((r_state == DEAD) && !r_blink) ? '0 : (ROWS'(1) << r_pos);
  assign bus.tick     = w_tick;
  assign bus.playing  = (r_state == PLAY);
  assign bus.dead     = (r_state == DEAD);
endmodule
